// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front-end for the 16-bit ALU.
// Registers one op, executes it for a cycle, keeps Z/V/N and evaluates branches.
module alu_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero_en,
  input  logic             alu_ovf_en,
  input  logic             alu_neg_en,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  input  logic [2:0]       cond,
  output logic             branch_taken
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } state_t;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_t state;
  state_t state_nx;
  op_t    op_q;
  logic   accept;
  logic   capture;

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !flush;
        if (!flush && req_valid)
          state_nx = EXEC;
      end
      EXEC: begin
        state_nx = flush ? IDLE : HOLD;
      end
      HOLD: begin
        // flush masks the response so no handshake can slip through
        rsp_valid = !flush;
        req_ready = rsp_ready && !flush;
        if (flush)
          state_nx = IDLE;
        else if (rsp_ready)
          state_nx = req_valid ? EXEC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept  = req_valid && req_ready;
  assign capture = (state == EXEC) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_q <= '0;
    else if (accept)
      op_q <= '{opcode: req_opcode, a: req_a, b: req_b};
  end

  assign alu_opcode = op_q.opcode;
  assign alu_in1    = op_q.a;
  assign alu_in2    = op_q.b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      flag_z     <= 1'b0;
      flag_v     <= 1'b0;
      flag_n     <= 1'b0;
    end else if (capture) begin
      rsp_result <= alu_out;
      if (alu_zero_en)
        flag_z <= (alu_out == '0);
      if (alu_neg_en)
        flag_n <= alu_out[WIDTH-1];
      if (alu_ovf_en)
        flag_v <= alu_ovf;
    end
  end

  always_comb begin
    branch_taken = 1'b0;
    unique case (cond)
      3'b000: branch_taken = !flag_z;
      3'b001: branch_taken = flag_z;
      3'b010: branch_taken = !flag_z && !flag_n;
      3'b011: branch_taken = flag_n;
      3'b100: branch_taken = flag_z || !flag_n;
      3'b101: branch_taken = flag_n || flag_z;
      3'b110: branch_taken = flag_v;
      3'b111: branch_taken = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vectors plus multi-cycle corner cases.
// A small ALU model answers the sequencer's alu_* outputs.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_opcode = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [15:0] alu_out;
  logic        alu_zero_en;
  logic        alu_ovf_en;
  logic        alu_neg_en;
  logic        alu_ovf;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic [2:0]  cond = '0;
  logic        branch_taken;

  int n_vec = 0;
  int n_err = 0;

  alu_op_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_zero_en(alu_zero_en),
    .alu_ovf_en(alu_ovf_en), .alu_neg_en(alu_neg_en),
    .alu_ovf(alu_ovf), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .flag_z(flag_z), .flag_v(flag_v),
    .flag_n(flag_n), .cond(cond), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [15:0] r;
    r           = 16'hFFFF;
    alu_zero_en = 1'b0;
    alu_ovf_en  = 1'b0;
    alu_neg_en  = 1'b0;
    alu_ovf     = 1'b0;
    case (alu_opcode)
      4'b0000: begin
        r = alu_in1 + alu_in2;
        {alu_zero_en, alu_ovf_en, alu_neg_en} = 3'b111;
        alu_ovf = (alu_in1[15] == alu_in2[15]) && (r[15] != alu_in1[15]);
      end
      4'b0001: begin
        r = alu_in1 - alu_in2;
        {alu_zero_en, alu_ovf_en, alu_neg_en} = 3'b111;
        alu_ovf = (alu_in1[15] != alu_in2[15]) && (r[15] != alu_in1[15]);
      end
      4'b0010: begin
        r = alu_in1 ^ alu_in2;
        alu_zero_en = 1'b1;
      end
      4'b1010: r = {alu_in1[15:8], alu_in2[7:0]};
      default: r = 16'hFFFF;
    endcase
    alu_out = r;
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        v;
    logic        n;
  } vec_t;

  vec_t        vt[8];
  logic [15:0] bb_a[4];
  logic [15:0] bb_b[4];
  logic [15:0] bb_r[4];
  logic [15:0] sa[4];
  logic [15:0] sb[4];

  function automatic logic bexp(logic [2:0] c, logic z, logic v, logic n);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge clk);
    chk("req_ready_idle", 16'(req_ready), 16'd1);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic do_chk,
                        input logic [15:0] er, input logic ez,
                        input logic ev, input logic en);
    issue(op, a, b);
    @(negedge clk);
    chk("exec_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("exec_alu_in1", alu_in1, a);
    @(negedge clk);
    chk("hold_rsp_valid", 16'(rsp_valid), 16'd1);
    if (do_chk) begin
      chk("result", rsp_result, er);
      chk("flags_zvn", 16'({flag_z, flag_v, flag_n}), 16'({ez, ev, en}));
      chk("branch", 16'(branch_taken), 16'(bexp(cond, ez, ev, en)));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    vt[0] = '{4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1};
    vt[1] = '{4'b0001, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[2] = '{4'b0000, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1};
    vt[3] = '{4'b0010, 16'h00F0, 16'h00F0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[4] = '{4'b1010, 16'hAB00, 16'h00CD, 16'hABCD, 1'b1, 1'b0, 1'b1};
    vt[5] = '{4'b1111, 16'h1234, 16'h5678, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vt[6] = '{4'b1100, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vt[7] = '{4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    bb_a = '{16'h0001, 16'h0010, 16'h0F0F, 16'h0001};
    bb_b = '{16'h0001, 16'h0001, 16'h00FF, 16'h0002};
    bb_r = '{16'h0002, 16'h000F, 16'h0FF0, 16'h0003};
    sa   = '{16'h0001, 16'h8000, 16'h8000, 16'h7FFF};
    sb   = '{16'h0001, 16'h0000, 16'h8000, 16'h0001};

    #12;
    chk("rst_req_ready", 16'(req_ready), 16'd1);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_result", rsp_result, 16'h0000);
    chk("rst_flags", 16'({flag_z, flag_v, flag_n}), 16'd0);
    chk("rst_alu", 16'(alu_opcode) | alu_in1 | alu_in2, 16'h0000);
    chk("rst_branch_ne", 16'(branch_taken), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;

    cond = 3'b110;
    for (int i = 0; i < 8; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, 1'b1,
             vt[i].res, vt[i].z, vt[i].v, vt[i].n);

    // back-to-back with rsp_ready held high
    begin
      int k;
      int r;
      k = 0;
      r = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        req_valid  = (k < 4);
        req_opcode = (k == 1) ? 4'b0001 : (k == 2) ? 4'b0010 : 4'b0000;
        req_a      = bb_a[k % 4];
        req_b      = bb_b[k % 4];
        chk("b2b_rsp_valid", 16'(rsp_valid), 16'((i % 2 == 0) && i > 0));
        if (rsp_valid) begin
          chk("b2b_result", rsp_result, bb_r[r % 4]);
          r++;
        end
        @(posedge clk);
        if (req_valid && req_ready)
          k++;
        #1 req_valid = 1'b0;
      end
      rsp_ready = 1'b0;
      chk("b2b_ops_issued", 16'(k), 16'd4);
    end

    // stall in HOLD with a competing request
    issue(4'b0000, 16'h0004, 16'h0004);
    @(negedge clk);
    req_valid  = 1'b1;
    req_opcode = 4'b0001;
    req_a      = 16'h0009;
    req_b      = 16'h0009;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 16'(rsp_valid), 16'd1);
      chk("stall_result", rsp_result, 16'h0008);
      chk("stall_req_ready", 16'(req_ready), 16'd0);
      chk("stall_flag_z", 16'(flag_z), 16'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // flush during EXEC of SUB 5-5
    issue(4'b0001, 16'h0005, 16'h0005);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("flush_exec_rsp_valid", 16'(rsp_valid), 16'd0);
      chk("flush_exec_flag_z", 16'(flag_z), 16'd0);
      chk("flush_exec_result", rsp_result, 16'h0008);
    end

    // flush during HOLD beats a ready consumer
    issue(4'b0000, 16'h0005, 16'h0005);
    @(negedge clk);
    @(negedge clk);
    flush     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("flush_hold_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("flush_hold_req_ready", 16'(req_ready), 16'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("flush_hold_idle", 16'({rsp_valid, req_ready}), 16'b01);

    // asynchronous reset while holding a flag-setting result
    issue(4'b0000, 16'h7FFF, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_flags", 16'({flag_v, flag_n}), 16'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("arst_flags", 16'({flag_z, flag_v, flag_n}), 16'd0);
    chk("arst_result", rsp_result, 16'h0000);
    chk("arst_alu_in1", alu_in1, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // cond sweep over all Z/V/N combinations
    for (int idx = 0; idx < 8; idx++) begin
      logic [2:0] zvn;
      zvn = 3'(idx);
      run_op(4'b0000, sa[zvn[1:0]], sb[zvn[1:0]], 1'b0, '0, 1'b0, 1'b0, 1'b0);
      run_op(4'b0010, 16'h0055, zvn[2] ? 16'h0055 : 16'h00AA,
             1'b0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("sweep_flags", 16'({flag_z, flag_v, flag_n}), 16'(zvn));
      for (int c = 0; c < 8; c++) begin
        cond = 3'(c);
        #1;
        chk("sweep_branch", 16'(branch_taken),
            16'(bexp(3'(c), zvn[2], zvn[1], zvn[0])));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequencing front-end for the 16-bit ALU datapath. Accepts one ALU operation at a time over a valid/ready handshake, registers the operands, and drives opcode and operands into the ALU for one execute cycle. It captures the result and updates the architectural Z/V/N flag register under the ALU's per-opcode flag enables, then returns the result over a second valid/ready handshake. Branch conditions are evaluated from the registered flags.

## Interface
Parameters:
- WIDTH, 16, datapath width; only 16 is supported.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous drop of any in-flight operation.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_opcode  in  4  ALU opcode.
- req_a, req_b  in  16  operands (ALU_In1, ALU_In2).
- alu_opcode  out  4  opcode driven to the ALU.
- alu_in1, alu_in2  out  16  registered operands driven to the ALU.
- alu_out  in  16  ALU result (combinational from alu_* outputs).
- alu_zero_en, alu_ovf_en, alu_neg_en  in  1  ALU flag-write enables.
- alu_ovf  in  1  raw signed overflow from the adder.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  16  captured result.
- flag_z, flag_v, flag_n  out  1  registered flags.
- cond  in  3  branch condition code.
- branch_taken  out  1  condition evaluated against registered flags.

## Operation
- States: IDLE, EXEC, HOLD. Reset state is IDLE.
- req_ready = (state==IDLE) | (state==HOLD & rsp_ready). It is 0 while flush is high.
- IDLE: on handshake, latch opcode/a/b into op registers and go to EXEC.
- EXEC: the op registers drive alu_opcode/alu_in1/alu_in2 for exactly this cycle. At the clock edge:
  - rsp_result <= alu_out.
  - If alu_zero_en: flag_z <= (alu_out==0).
  - If alu_neg_en: flag_n <= alu_out[15].
  - If alu_ovf_en: flag_v <= alu_ovf.
  - Disabled flags hold their value. Go to HOLD.
- HOLD: rsp_valid=1; rsp_result is stable until handshake.
  - On rsp_ready & req_valid: accept the new request and go to EXEC (back-to-back).
  - On rsp_ready without req_valid: go to IDLE.
- Unsupported opcodes (1100, 1101, 1111) are sequenced normally. The result is 16'hFFFF, as driven by the ALU, and all enables are 0, so flags are unchanged.
- In IDLE and HOLD, the alu_* outputs hold their last values. No flag update occurs outside EXEC.
- branch_taken (combinational from the flag registers):
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | !N
  - 101 LE: N | Z
  - 110 OV: V
  - 111 always 1
- flush in EXEC suppresses the result capture and flag update, and the block goes to IDLE. flush in HOLD drops rsp_valid and goes to IDLE. flush wins over every simultaneous handshake.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_result 0, flag_z/v/n 0, alu_opcode 0, alu_in1 0, alu_in2 0, branch_taken per cond with flags 0.
- Latency: request accepted at edge N; EXEC during cycle N+1; rsp_valid high from N+2.
- Throughput: one op per 2 cycles with rsp_ready held high.
- Flags written by an op are visible on flag_*/branch_taken in the same cycle rsp_valid rises.
- rst_n asserted mid-operation returns everything to reset values immediately. No partial flag update survives.
- A held response with rsp_ready low stalls indefinitely. Flags and result stay stable and req_ready stays 0.

## Test plan
- ADD (0000) a=16'h7FFF, b=16'h0001 -> rsp_result 16'h8000 at N+2; V=1, N=1, Z=0; cond 110 gives branch_taken 1.
- SUB (0001) a=16'h1234, b=16'h1234 -> result 0, Z=1, N=0, V=0. Then XOR (0010) a=b=16'h00F0 with a prior N=1 -> Z=1, N and V unchanged.
- LLB (1010) a=16'hAB00, b=16'h00CD -> result 16'hABCD; flags unchanged from the previous op.
- Back-to-back: rsp_ready and req_valid held high for 4 ops -> rsp_valid pulses every 2 cycles with the correct results; rsp_ready low 3 cycles in HOLD -> result stable, req_ready 0.
- flush during EXEC of SUB 5-5 -> no rsp_valid and flag_z unchanged. rst_n low during HOLD -> rsp_valid 0 and flags 0 asynchronously.
- Opcode 1111 -> rsp_result 16'hFFFF and flags unchanged. Sweep cond 000-111 against all 8 Z/V/N combinations, checking branch_taken against the table.
